// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - frame codes, payload lengths, field offsets and FSM states for cmd_loader
package cmd_pkg;

  localparam logic [7:0] TYPE_CMD  = 8'h01;
  localparam logic [7:0] TYPE_TIME = 8'h02;

  localparam int LEN_CMD  = 43;
  localparam int LEN_TIME = 8;
  localparam int SHADOW_W = LEN_CMD * 8;

  // Byte offsets of the command fields within a type-01 payload
  localparam int OFF_FREQ         = 0;
  localparam int OFF_FREQ_STEP    = 6;
  localparam int OFF_FREQ_RATE    = 12;
  localparam int OFF_TIME_START   = 16;
  localparam int OFF_N_IMPULSE    = 24;
  localparam int OFF_TYPE_IMPULSE = 26;
  localparam int OFF_TI           = 27;
  localparam int OFF_TP           = 31;
  localparam int OFF_TBLANK1      = 35;
  localparam int OFF_TBLANK2      = 39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_PAYLOAD,
    ST_CHECK,
    ST_STROBE
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_loader_if.sv
// rtl/cmd_loader_if.sv - byte link from the MCU into cmd_loader
interface cmd_loader_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/cmd_timeout.sv
// rtl/cmd_timeout.sv - inter-byte watchdog; expire pulses after TIMEOUT_CYC cycles without clear
module cmd_timeout #(
  parameter int TIMEOUT_CYC = 4800
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expire = enable && !clear && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_loader.sv
// rtl/cmd_loader.sv - decodes MCU byte frames into command fields and time-preset requests
module cmd_loader
  import cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC  = 4800,
  parameter int         WR_PULSE_LEN = 4
) (
  input  logic        CLK,
  input  logic        rst_n,
  cmd_loader_if.slave link,
  output logic [47:0] FREQ,
  output logic [47:0] FREQ_STEP,
  output logic [31:0] FREQ_RATE,
  output logic [63:0] TIME_START,
  output logic [15:0] N_impulse,
  output logic [1:0]  TYPE_impulse,
  output logic [31:0] Interval_Ti,
  output logic [31:0] Interval_Tp,
  output logic [31:0] Tblank1,
  output logic [31:0] Tblank2,
  output logic        SPI_WR,
  output logic [63:0] TIME_INIT,
  output logic        SYS_TIME_UPDATE,
  input  logic        SYS_TIME_UPDATE_OK,
  output logic [7:0]  err_cnt
);

  state_t                state;
  logic [SHADOW_W-1:0]   shadow;
  logic [5:0]            byte_cnt;
  logic [7:0]            chk;
  logic                  is_time;
  logic [3:0]            pulse_cnt;
  logic                  accept;
  logic                  in_frame;
  logic                  expire;
  logic                  unused_type_hi;

  assign link.byte_ready = (state != ST_STROBE);
  assign accept          = link.byte_valid && link.byte_ready;
  assign in_frame        = state inside {ST_TYPE, ST_PAYLOAD, ST_CHECK};
  assign unused_type_hi  = ^shadow[SHADOW_W-1-8*OFF_TYPE_IMPULSE -: 6];

  cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (CLK),
    .rst_n  (rst_n),
    .enable (in_frame),
    .clear  (accept),
    .expire (expire)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      shadow          <= '0;
      byte_cnt        <= '0;
      chk             <= '0;
      is_time         <= 1'b0;
      pulse_cnt       <= '0;
      FREQ            <= '0;
      FREQ_STEP       <= '0;
      FREQ_RATE       <= '0;
      TIME_START      <= '0;
      N_impulse       <= '0;
      TYPE_impulse    <= '0;
      Interval_Ti     <= '0;
      Interval_Tp     <= '0;
      Tblank1         <= '0;
      Tblank2         <= '0;
      SPI_WR          <= 1'b0;
      TIME_INIT       <= '0;
      SYS_TIME_UPDATE <= 1'b0;
      err_cnt         <= '0;
    end else begin
      // A commit in CHECK below overrides this clear when both land together
      if (SYS_TIME_UPDATE_OK) SYS_TIME_UPDATE <= 1'b0;

      if (expire) begin
        state   <= ST_IDLE;
        err_cnt <= sat_inc(err_cnt);
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept && link.byte_data == SYNC_BYTE) state <= ST_TYPE;
          end
          ST_TYPE: begin
            if (accept) begin
              chk <= link.byte_data;
              if (link.byte_data == TYPE_CMD) begin
                is_time  <= 1'b0;
                byte_cnt <= 6'(LEN_CMD);
                state    <= ST_PAYLOAD;
              end else if (link.byte_data == TYPE_TIME) begin
                is_time  <= 1'b1;
                byte_cnt <= 6'(LEN_TIME);
                state    <= ST_PAYLOAD;
              end else begin
                state   <= ST_IDLE;
                err_cnt <= sat_inc(err_cnt);
              end
            end
          end
          ST_PAYLOAD: begin
            if (accept) begin
              shadow   <= {shadow[SHADOW_W-9:0], link.byte_data};
              chk      <= chk ^ link.byte_data;
              byte_cnt <= byte_cnt - 6'd1;
              if (byte_cnt == 6'd1) state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (accept) begin
              if (link.byte_data == chk) begin
                state     <= ST_STROBE;
                pulse_cnt <= 4'(WR_PULSE_LEN - 1);
                if (is_time) begin
                  TIME_INIT       <= shadow[63:0];
                  SYS_TIME_UPDATE <= 1'b1;
                end else begin
                  FREQ         <= shadow[SHADOW_W-1-8*OFF_FREQ         -: 48];
                  FREQ_STEP    <= shadow[SHADOW_W-1-8*OFF_FREQ_STEP    -: 48];
                  FREQ_RATE    <= shadow[SHADOW_W-1-8*OFF_FREQ_RATE    -: 32];
                  TIME_START   <= shadow[SHADOW_W-1-8*OFF_TIME_START   -: 64];
                  N_impulse    <= shadow[SHADOW_W-1-8*OFF_N_IMPULSE    -: 16];
                  TYPE_impulse <= shadow[SHADOW_W-7-8*OFF_TYPE_IMPULSE -: 2];
                  Interval_Ti  <= shadow[SHADOW_W-1-8*OFF_TI           -: 32];
                  Interval_Tp  <= shadow[SHADOW_W-1-8*OFF_TP           -: 32];
                  Tblank1      <= shadow[SHADOW_W-1-8*OFF_TBLANK1      -: 32];
                  Tblank2      <= shadow[SHADOW_W-1-8*OFF_TBLANK2      -: 32];
                  SPI_WR       <= 1'b1;
                end
              end else begin
                state   <= ST_IDLE;
                err_cnt <= sat_inc(err_cnt);
              end
            end
          end
          ST_STROBE: begin
            if (pulse_cnt == 4'd0) begin
              SPI_WR <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              pulse_cnt <= pulse_cnt - 4'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
